// File: rtl/lsu_sram_slave_if.sv
// AXI4-Lite bus between the EXU load/store master and the data-memory responder.
interface lsu_sram_slave_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_sram_slave.sv
// Data-memory responder for the EXU load/store path: word-addressed SRAM with
// independent read and write engines, programmable latencies and an optional
// awready stall that forces the master to deliver W ahead of AW.
module lsu_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1,
  parameter int WR_LAT      = 1,
  parameter int AW_STALL    = 0
) (
  input logic             clk,
  input logic             rst,
  lsu_sram_slave_if.slave bus
);
  localparam int         DATA_W      = 32;
  localparam int         IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] RD_CNT0     = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] WR_CNT0     = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;
  localparam logic [1:0] STALL0      = 2'(AW_STALL);
  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_WAIT, W_RESP} wstate_t;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'(addr >> 2);
  endfunction

  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> 2) >= 32'(DEPTH_WORDS);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // ---------------- read engine ----------------
  rstate_t           r_rstate, w_rstate_nxt;
  logic [3:0]        r_rcnt;
  logic [IDX_W-1:0]  r_ridx;
  logic              r_roor;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              w_ar_hs, w_rsample, w_r_oor;
  logic [IDX_W-1:0]  w_r_idx;

  assign bus.arready = (r_rstate == R_IDLE);
  assign bus.rvalid  = (r_rstate == R_RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign w_ar_hs     = bus.arvalid && (r_rstate == R_IDLE);
  // With RD_LAT=1 the sample happens on the handshake edge, so use the live address.
  assign w_r_idx     = w_ar_hs ? word_idx(bus.araddr) : r_ridx;
  assign w_r_oor     = w_ar_hs ? out_of_range(bus.araddr) : r_roor;

  // Read next-state: sample memory on every entry into R_RESP.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rsample    = 1'b0;
    unique case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
        if (RD_LAT == 1) begin
          w_rstate_nxt = R_RESP;
          w_rsample    = 1'b1;
        end else begin
          w_rstate_nxt = R_WAIT;
        end
      end
      R_WAIT: if (r_rcnt == 4'd0) begin
        w_rstate_nxt = R_RESP;
        w_rsample    = 1'b1;
      end
      R_RESP: if (bus.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read state, latency counter and held response; rdata reads the pre-commit word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= 4'd0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OK;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rcnt   <= (r_rstate == R_WAIT) ? r_rcnt - 4'd1 : RD_CNT0;
      if (w_rsample) begin
        r_rdata <= w_r_oor ? '0 : r_mem[w_r_idx];
        r_rresp <= w_r_oor ? RESP_DECERR : RESP_OK;
      end
    end
  end

  // Read request holding registers, loaded only on the AR handshake.
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_ridx <= word_idx(bus.araddr);
      r_roor <= out_of_range(bus.araddr);
    end
  end

  // ---------------- write engine ----------------
  wstate_t           r_wstate, w_wstate_nxt;
  logic [3:0]        r_wcnt;
  logic [1:0]        r_stall;
  logic              r_aw_got, r_w_got;
  logic [IDX_W-1:0]  r_aw_idx;
  logic              r_aw_oor;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;
  logic              w_awready, w_wready, w_aw_hs, w_w_hs, w_commit;
  logic [IDX_W-1:0]  w_c_idx;
  logic              w_c_oor;
  logic [DATA_W-1:0] w_c_data;
  logic [3:0]        w_c_strb;

  assign w_awready = ((r_wstate == W_IDLE) && (AW_STALL == 0)) ||
                     ((r_wstate == W_COLLECT) && !r_aw_got && (r_stall == 2'd0));
  assign w_wready  = (r_wstate == W_IDLE) || ((r_wstate == W_COLLECT) && !r_w_got);
  assign w_aw_hs   = bus.awvalid && w_awready;
  assign w_w_hs    = bus.wvalid && w_wready;
  assign bus.awready = w_awready;
  assign bus.wready  = w_wready;
  assign bus.bvalid  = (r_wstate == W_RESP);
  assign bus.bresp   = r_bresp;
  // A channel captured on this very edge is taken from the bus, otherwise from its holding register.
  assign w_c_idx   = w_aw_hs ? word_idx(bus.awaddr) : r_aw_idx;
  assign w_c_oor   = w_aw_hs ? out_of_range(bus.awaddr) : r_aw_oor;
  assign w_c_data  = w_w_hs ? bus.wdata : r_wdata;
  assign w_c_strb  = w_w_hs ? bus.wstrb : r_wstrb;

  // Write next-state: the commit edge is the one that enters W_RESP.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    unique case (r_wstate)
      W_IDLE, W_COLLECT: begin
        if ((w_aw_hs || r_aw_got) && (w_w_hs || r_w_got)) begin
          if (WR_LAT == 1) begin
            w_wstate_nxt = W_RESP;
            w_commit     = 1'b1;
          end else begin
            w_wstate_nxt = W_WAIT;
          end
        end else if (w_aw_hs || w_w_hs) begin
          w_wstate_nxt = W_COLLECT;
        end
      end
      W_WAIT: if (r_wcnt == 4'd0) begin
        w_wstate_nxt = W_RESP;
        w_commit     = 1'b1;
      end
      W_RESP: if (bus.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write state, capture flags, awready stall and latency counters, response code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= 4'd0;
      r_stall  <= STALL0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_bresp  <= RESP_OK;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= (r_wstate == W_WAIT) ? r_wcnt - 4'd1 : WR_CNT0;
      if (r_wstate != W_COLLECT)  r_stall <= STALL0;
      else if (r_stall != 2'd0)   r_stall <= r_stall - 2'd1;
      if (w_wstate_nxt == W_IDLE) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_got <= 1'b1;
        if (w_w_hs)  r_w_got  <= 1'b1;
      end
      if (w_commit) r_bresp <= w_c_oor ? RESP_DECERR : RESP_OK;
    end
  end

  // Write request holding registers, each loaded on its own handshake.
  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_aw_idx <= word_idx(bus.awaddr);
      r_aw_oor <= out_of_range(bus.awaddr);
    end
    if (w_w_hs) begin
      r_wdata <= bus.wdata;
      r_wstrb <= bus.wstrb;
    end
  end

  // SRAM byte-lane update on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit && !w_c_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_strb[i]) r_mem[w_c_idx][8*i +: 8] <= w_c_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_lsu_sram_slave.sv
// Bench for lsu_sram_slave: two instances (fast A: RD1/WR1/no stall, slow B:
// RD4/WR3/AW_STALL2) driven one at a time, checked against a byte-level memory model.
module tb_lsu_sram_slave;
  localparam int A_RD = 1, A_WR = 1, B_RD = 4, B_WR = 3, B_STALL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_sram_slave_if ifa ();
  lsu_sram_slave_if ifb ();

  lsu_sram_slave #(.DEPTH_WORDS(1024), .RD_LAT(A_RD), .WR_LAT(A_WR), .AW_STALL(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  lsu_sram_slave #(.DEPTH_WORDS(1024), .RD_LAT(B_RD), .WR_LAT(B_WR), .AW_STALL(B_STALL))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic        sel = 1'b0;
  logic [31:0] m_araddr = '0, m_awaddr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic        m_arvalid = 1'b0, m_rready = 1'b0, m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0;

  assign ifa.araddr = m_araddr;  assign ifb.araddr = m_araddr;
  assign ifa.awaddr = m_awaddr;  assign ifb.awaddr = m_awaddr;
  assign ifa.wdata  = m_wdata;   assign ifb.wdata  = m_wdata;
  assign ifa.wstrb  = m_wstrb;   assign ifb.wstrb  = m_wstrb;
  assign ifa.arvalid = !sel && m_arvalid;  assign ifb.arvalid = sel && m_arvalid;
  assign ifa.rready  = !sel && m_rready;   assign ifb.rready  = sel && m_rready;
  assign ifa.awvalid = !sel && m_awvalid;  assign ifb.awvalid = sel && m_awvalid;
  assign ifa.wvalid  = !sel && m_wvalid;   assign ifb.wvalid  = sel && m_wvalid;
  assign ifa.bready  = !sel && m_bready;   assign ifb.bready  = sel && m_bready;

  wire        s_arready = sel ? ifb.arready : ifa.arready;
  wire        s_rvalid  = sel ? ifb.rvalid  : ifa.rvalid;
  wire [31:0] s_rdata   = sel ? ifb.rdata   : ifa.rdata;
  wire [1:0]  s_rresp   = sel ? ifb.rresp   : ifa.rresp;
  wire        s_awready = sel ? ifb.awready : ifa.awready;
  wire        s_wready  = sel ? ifb.wready  : ifa.wready;
  wire        s_bvalid  = sel ? ifb.bvalid  : ifa.bvalid;
  wire [1:0]  s_bresp   = sel ? ifb.bresp   : ifa.bresp;

  int n_chk = 0;
  int n_fail = 0;

  // Reference memory: one per instance, with a per-byte "has been written" mask.
  logic [31:0] mdl [2][1024];
  logic [3:0]  kn  [2][1024];

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < 32'd1024;
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) begin
          mdl[sel][a[11:2]][8*i +: 8] = d[8*i +: 8];
          kn[sel][a[11:2]][i] = 1'b1;
        end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return in_rng(a) ? mdl[sel][a[11:2]] : 32'd0;
  endfunction

  function automatic bit mdl_known(input logic [31:0] a);
    return !in_rng(a) || (kn[sel][a[11:2]] == 4'hF);
  endfunction

  // Present AW and W together and hold each until its own handshake.
  task automatic present_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    m_awaddr = a; m_wdata = d; m_wstrb = s; m_awvalid = 1'b1; m_wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      hs_aw = m_awvalid && s_awready;
      hs_w  = m_wvalid && s_wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; m_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  m_wvalid = 1'b0; end
      cyc++;
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    ok = aw_done && w_done;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bdly,
                          output logic [1:0] resp, output int lat, output bit stable);
    bit ok;
    present_aw_w(a, d, s, ok);
    lat = 1;
    while (!s_bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!ok) lat = -1;
    resp = s_bresp;
    stable = 1;
    repeat (bdly) begin
      @(posedge clk); #1;
      if (!s_bvalid || s_bresp !== resp) stable = 0;
    end
    m_bready = 1'b1;
    @(posedge clk); #1;
    m_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly,
                         output logic [31:0] data, output logic [1:0] resp, output int lat, output bit stable);
    int cyc;
    bit hs;
    cyc = 0; hs = 0;
    m_araddr = a; m_arvalid = 1'b1;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    m_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!hs) lat = -1;
    data = s_rdata; resp = s_rresp;
    stable = 1;
    repeat (rdly) begin
      @(posedge clk); #1;
      if (!s_rvalid || s_rdata !== data || s_rresp !== resp) stable = 0;
    end
    m_rready = 1'b1;
    @(posedge clk); #1;
    m_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] got, want;
    for (int k = 0; k < 2; k++) begin
      sel = k[0]; #1;
      got  = {s_arready, s_awready, s_wready, s_rvalid, s_bvalid, s_rdata, s_rresp, s_bresp};
      want = {1'b1, (k == 0), 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
      n_chk++; if (got !== want) begin n_fail++; $display("FAIL reset_values dut%0d got %h want %h", k, got, want); end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sel = 1'b0;
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] rd; int lat; bit st;
    sel = 1'b0;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, resp, lat, st);
    mdl_write(32'h10, 32'hDEADBEEF, 4'hF);
    n_chk++; if (resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp got %b want 00", resp); end
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency got %0d want 1", lat); end
    do_read(32'h10, 0, rd, resp, lat, st);
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
    n_chk++; if (resp !== 2'b00) begin n_fail++; $display("FAIL rd_rresp got %b want 00", resp); end
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL rd_latency got %0d want 1", lat); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic [31:0] rd; int lat; bit st;
    sel = 1'b0;
    do_write(32'h10, 32'h00000055, 4'b0001, 0, resp, lat, st);
    mdl_write(32'h10, 32'h00000055, 4'b0001);
    do_read(32'h12, 0, rd, resp, lat, st);
    n_chk++; if (rd !== 32'hDEADBE55) begin n_fail++; $display("FAIL partial_strobe got %h want deadbe55", rd); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] rd, d; int lat; bit st;
    sel = 1'b0;
    do_write(32'h0, 32'hA5A50001, 4'hF, 0, resp, lat, st);
    mdl_write(32'h0, 32'hA5A50001, 4'hF);
    d = $urandom;
    do_write(32'h1000, d, 4'hF, 1, resp, lat, st);
    n_chk++; if (resp !== 2'b11) begin n_fail++; $display("FAIL oor_bresp got %b want 11", resp); end
    do_read(32'h1000, 0, rd, resp, lat, st);
    n_chk++; if (resp !== 2'b11) begin n_fail++; $display("FAIL oor_rresp got %b want 11", resp); end
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oor_rdata got %h want 0", rd); end
    do_read(32'hFFFF_FFFC, 0, rd, resp, lat, st);
    n_chk++; if ({rd, resp} !== {32'd0, 2'b11}) begin n_fail++; $display("FAIL oor_top got %h/%b want 0/11", rd, resp); end
    do_read(32'h0, 0, rd, resp, lat, st);
    n_chk++; if (rd !== 32'hA5A50001) begin n_fail++; $display("FAIL oor_word0 got %h want a5a50001", rd); end
  endtask

  task automatic test_concurrent();
    logic [1:0] wresp, rresp; logic [31:0] rd, oldv, newv; int wlat, rlat; bit st1, st2;
    sel = 1'b0;
    oldv = mdl_read(32'h10);
    newv = $urandom;
    fork
      do_read(32'h10, 0, rd, rresp, rlat, st1);
      do_write(32'h10, newv, 4'hF, 0, wresp, wlat, st2);
    join
    mdl_write(32'h10, newv, 4'hF);
    n_chk++; if (rd !== oldv) begin n_fail++; $display("FAIL same_edge_read got %h want %h", rd, oldv); end
    n_chk++; if ({rlat, wlat} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL concurrent_lat got %0d/%0d want 1/1", rlat, wlat); end
    do_read(32'h10, 0, rd, rresp, rlat, st1);
    n_chk++; if (rd !== newv) begin n_fail++; $display("FAIL after_concurrent got %h want %h", rd, newv); end
  endtask

  task automatic test_split_aw_w();
    logic [1:0] resp; logic [31:0] rd, d; int lat; bit st;
    sel = 1'b1;
    d = $urandom;
    m_wdata = d; m_wstrb = 4'hF; m_wvalid = 1'b1; m_awaddr = 32'h20;
    @(negedge clk);
    n_chk++; if ({s_wready, s_awready} !== 2'b10) begin n_fail++; $display("FAIL split_idle_ready got %b want 10", {s_wready, s_awready}); end
    @(posedge clk); #1;
    m_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m_awvalid = 1'b1;
      @(negedge clk);
      n_chk++; if (s_wready !== 1'b0) begin n_fail++; $display("FAIL split_wready cyc%0d got %b want 0", i, s_wready); end
      n_chk++; if (s_awready !== (i == 2)) begin n_fail++; $display("FAIL split_awready cyc%0d got %b want %b", i, s_awready, (i == 2)); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    lat = 1;
    while (!s_bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_chk++; if (lat !== B_WR) begin n_fail++; $display("FAIL split_wr_latency got %0d want %0d", lat, B_WR); end
    n_chk++; if (s_bresp !== 2'b00) begin n_fail++; $display("FAIL split_bresp got %b want 00", s_bresp); end
    m_bready = 1'b1;
    @(posedge clk); #1;
    m_bready = 1'b0;
    mdl_write(32'h20, d, 4'hF);
    do_read(32'h20, 0, rd, resp, lat, st);
    n_chk++; if (rd !== d) begin n_fail++; $display("FAIL split_readback got %h want %h", rd, d); end
    n_chk++; if (lat !== B_RD) begin n_fail++; $display("FAIL b_rd_latency got %0d want %0d", lat, B_RD); end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [31:0] d, rd; int lat; bit st, hs;
    sel = 1'b1;
    d = $urandom;
    do_write(32'h40, d, 4'hF, 0, resp, lat, st);
    mdl_write(32'h40, d, 4'hF);
    m_araddr = 32'h40; m_arvalid = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = s_arready;
      @(posedge clk); #1;
    end
    m_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_chk++; if (lat !== B_RD) begin n_fail++; $display("FAIL bp_rd_latency got %0d want %0d", lat, B_RD); end
    // A second AR arrives while the first response is stalled and must wait.
    m_araddr = 32'h20; m_arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if ({s_rvalid, s_rdata, s_arready} !== {1'b1, d, 1'b0})
        begin n_fail++; $display("FAIL bp_hold cyc%0d got %b/%h/%b want 1/%h/0", c, s_rvalid, s_rdata, s_arready, d); end
    end
    m_rready = 1'b1;
    @(posedge clk); #1;
    m_rready = 1'b0;
    n_chk++; if ({s_arready, s_rvalid} !== 2'b10) begin n_fail++; $display("FAIL bp_turnaround got %b want 10", {s_arready, s_rvalid}); end
    @(posedge clk); #1;
    m_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = s_rdata;
    n_chk++; if ({rd, lat} !== {mdl_read(32'h20), B_RD}) begin n_fail++; $display("FAIL queued_ar got %h/%0d want %h/%0d", rd, lat, mdl_read(32'h20), B_RD); end
    m_rready = 1'b1;
    @(posedge clk); #1;
    m_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] rd, oldv; logic [7:0] got; int lat; bit ok, st;
    sel = 1'b1;
    oldv = mdl_read(32'h40);
    present_aw_w(32'h40, ~oldv, 4'hF, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_capture got %b want 1", ok); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    got = {s_arready, s_awready, s_wready, s_rvalid, s_bvalid, s_rresp == 2'b00, s_bresp == 2'b00, s_rdata == 32'd0};
    n_chk++; if (got !== 8'b10100111) begin n_fail++; $display("FAIL rstmid_outputs got %b want 10100111", got); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_bvalid got %b want 0", s_bvalid); end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp got %b want 0", s_bvalid); end
    do_read(32'h40, 0, rd, resp, lat, st);
    n_chk++; if (rd !== oldv) begin n_fail++; $display("FAIL rstmid_mem got %h want %h", rd, oldv); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] resp; int lat, dly; bit st;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      for (int w = 0; w < 16; w++) begin
        d = $urandom;
        do_write(32'(w * 4), d, 4'hF, 0, resp, lat, st);
        mdl_write(32'(w * 4), d, 4'hF);
      end
      for (int it = 0; it < 40; it++) begin
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
        if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom & 32'h7FFF_FFFF);
        dly = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom; s = 4'($urandom);
          do_write(a, d, s, dly, resp, lat, st);
          mdl_write(a, d, s);
          n_chk++; if ({resp, lat} !== {(in_rng(a) ? 2'b00 : 2'b11), (k == 1 ? B_WR : A_WR)})
            begin n_fail++; $display("FAIL rnd_write dut%0d a=%h got %b/%0d", k, a, resp, lat); end
          n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd_b_stable dut%0d got %b want 1", k, st); end
        end else begin
          do_read(a, dly, rd, resp, lat, st);
          n_chk++; if ({resp, lat} !== {(in_rng(a) ? 2'b00 : 2'b11), (k == 1 ? B_RD : A_RD)})
            begin n_fail++; $display("FAIL rnd_read dut%0d a=%h got %b/%0d", k, a, resp, lat); end
          n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd_r_stable dut%0d got %b want 1", k, st); end
          if (mdl_known(a)) begin
            n_chk++; if (rd !== mdl_read(a)) begin n_fail++; $display("FAIL rnd_rdata dut%0d a=%h got %h want %h", k, a, rd, mdl_read(a)); end
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 1024; w++) begin mdl[k][w] = '0; kn[k][w] = '0; end
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_concurrent();
    test_split_aw_w();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
